aes_dec_arbiter: RTL and testbench

AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

---
 rtl/aes_dec_arb_pkg.sv | 28 ++
 rtl/aes_dec_arb_pick.sv | 36 +++
 rtl/aes_dec_arbiter.sv | 135 +++++++++++++
 tb/tb_aes_dec_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_arb_pkg.sv
// Shared types and constants for the AES decipher arbiter: FSM encoding,
// round counts per key length and the key-length encodings.
package aes_dec_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   localparam logic [3:0] AES128_ROUNDS = 4'ha;
   localparam logic [3:0] AES256_ROUNDS = 4'he;

   localparam logic KEYLEN_128 = 1'b0;
   localparam logic KEYLEN_256 = 1'b1;

   function automatic logic [3:0] num_rounds(input logic keylen);
      logic [3:0] n;
      case (keylen)
         KEYLEN_128: n = AES128_ROUNDS;
         KEYLEN_256: n = AES256_ROUNDS;
         default:    n = AES128_ROUNDS;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/aes_dec_arb_pick.sv
// Two-way requester picker. AES_DEC_ARB_RR_EN selects round-robin (ptr names
// the favoured requester on a tie); otherwise requester 0 has fixed priority.
module aes_dec_arb_pick (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win
);

`ifdef AES_DEC_ARB_RR_EN
   // Round-robin: only a tie consults the pointer.
   always_comb begin
      win = 2'b00;
      if (req == 2'b11) begin
         win = ptr ? 2'b10 : 2'b01;
      end else begin
         win = req;
      end
   end
`else
   logic ptr_unused_s;
   assign ptr_unused_s = ptr;

   // Fixed priority: requester 0 over requester 1.
   always_comb begin
      win = 2'b00;
      if (req[0]) begin
         win = 2'b01;
      end else if (req[1]) begin
         win = 2'b10;
      end else begin
         win = 2'b00;
      end
   end
`endif

endmodule

// File: rtl/aes_dec_arbiter.sv
// Arbitrates two requesters onto one AES decipher datapath.
// Define AES_DEC_ARB_RR_EN for round-robin selection (default: fixed priority).
module aes_dec_arbiter
   import aes_dec_arb_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req,
   input  logic [127:0] block0,
   input  logic [127:0] block1,
   input  logic         keylen0,
   input  logic         keylen1,
   output logic [1:0]   grant,
   output logic [1:0]   done,
   output logic [127:0] result,
   input  logic         key_ready,
   output logic         dec_next,
   output logic         dec_keylen,
   output logic [127:0] dec_block,
   input  logic         dec_ready,
   input  logic [3:0]   dec_round,
   input  logic [127:0] dec_new_block,
   output logic [3:0]   key_round
);

   state_t         state_r, state_nxt_s;
   logic [1:0]     grant_r, grant_nxt_s;
   logic [1:0]     done_r, done_nxt_s;
   logic [127:0]   result_r, result_nxt_s;
   logic [127:0]   block_r, block_nxt_s;
   logic           keylen_r, keylen_nxt_s;
   logic           next_r, next_nxt_s;
   logic           ptr_r, ptr_nxt_s;
   logic [1:0]     win_s;
   logic           start_s;
   logic [3:0]     rounds_s;
   logic [3:0]     key_round_s;

   aes_dec_arb_pick u_pick (
      .req (req),
      .ptr (ptr_r),
      .win (win_s)
   );

   assign start_s = (req != 2'b00) && key_ready && dec_ready;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         grant_r  <= 2'b00;
         done_r   <= 2'b00;
         result_r <= 128'h0;
         block_r  <= 128'h0;
         keylen_r <= 1'b0;
         next_r   <= 1'b0;
         ptr_r    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         grant_r  <= grant_nxt_s;
         done_r   <= done_nxt_s;
         result_r <= result_nxt_s;
         block_r  <= block_nxt_s;
         keylen_r <= keylen_nxt_s;
         next_r   <= next_nxt_s;
         ptr_r    <= ptr_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:      if (start_s) state_nxt_s = START; else state_nxt_s = IDLE;
         START:     state_nxt_s = WAIT_BUSY;
         WAIT_BUSY: if (!dec_ready) state_nxt_s = WAIT_DONE; else state_nxt_s = WAIT_BUSY;
         WAIT_DONE: if (dec_ready) state_nxt_s = IDLE; else state_nxt_s = WAIT_DONE;
         default:   state_nxt_s = IDLE;
      endcase
   end

   // Output next values; dec_next is registered out of START so it trails grant by one cycle.
   always_comb begin
      grant_nxt_s  = grant_r;
      done_nxt_s   = 2'b00;
      result_nxt_s = result_r;
      block_nxt_s  = block_r;
      keylen_nxt_s = keylen_r;
      next_nxt_s   = 1'b0;
      ptr_nxt_s    = ptr_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               grant_nxt_s  = win_s;
               block_nxt_s  = win_s[1] ? block1 : block0;
               keylen_nxt_s = win_s[1] ? keylen1 : keylen0;
               ptr_nxt_s    = win_s[0];
            end else begin
               grant_nxt_s  = 2'b00;
            end
         end
         START: next_nxt_s = 1'b1;
         WAIT_BUSY: next_nxt_s = 1'b0;
         WAIT_DONE: begin
            if (dec_ready) begin
               result_nxt_s = dec_new_block;
               done_nxt_s   = grant_r;
               grant_nxt_s  = 2'b00;
            end else begin
               done_nxt_s   = 2'b00;
            end
         end
         default: grant_nxt_s = 2'b00;
      endcase
   end

   // Round-key index counts down as the datapath counts rounds up.
   always_comb begin
      rounds_s = num_rounds(keylen_r);
      if (dec_round <= rounds_s) begin
         key_round_s = rounds_s - dec_round;
      end else begin
         key_round_s = 4'h0;
      end
   end

   assign grant      = grant_r;
   assign done       = done_r;
   assign result     = result_r;
   assign dec_block  = block_r;
   assign dec_keylen = keylen_r;
   assign dec_next   = next_r;
   assign key_round  = key_round_s;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Directed self-checking bench for aes_dec_arbiter with a behavioural datapath stub.
module tb_aes_dec_arbiter;

   localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B1 = 128'h0123456789abcdef0f1e2d3c4b5a6978;
   localparam logic [127:0] B2 = 128'hcafef00d11112222333344445555aaaa;
   localparam logic [127:0] B3 = 128'h5a5a5a5aa5a5a5a5f0f0f0f00f0f0f0f;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req;
   logic [127:0] block0, block1;
   logic         keylen0, keylen1;
   logic [1:0]   grant, done;
   logic [127:0] result;
   logic         key_ready;
   logic         dec_next, dec_keylen;
   logic [127:0] dec_block;
   logic         dec_ready;
   logic [3:0]   dec_round;
   logic [127:0] dec_new_block;
   logic [3:0]   key_round;

   int checks = 0;
   int errors = 0;
   logic force_busy = 1'b0;
   int busy_cnt = 0;

   logic [1:0] g, dv;
   int nn, na, ra, da, cnt;
   logic [1:0] exp_seq [4];

   aes_dec_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .block0(block0), .block1(block1),
      .keylen0(keylen0), .keylen1(keylen1), .grant(grant), .done(done),
      .result(result), .key_ready(key_ready), .dec_next(dec_next),
      .dec_keylen(dec_keylen), .dec_block(dec_block), .dec_ready(dec_ready),
      .dec_round(dec_round), .dec_new_block(dec_new_block), .key_round(key_round)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] dp_model(input logic [127:0] ct);
      if (ct == CT) return PT;
      return ct ^ {4{32'hdeadbeef}};
   endfunction

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Datapath stub: drops ready on dec_next, answers three cycles later.
   initial begin
      dec_ready = 1'b0;
      dec_new_block = 128'h0;
      forever begin
         @(negedge clk);
         if (force_busy) begin
            dec_ready = 1'b0;
            busy_cnt = 0;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               dec_ready = 1'b1;
               dec_new_block = dp_model(dec_block);
            end
         end else if (dec_next) begin
            dec_ready = 1'b0;
            busy_cnt = 3;
         end else begin
            dec_ready = 1'b1;
         end
      end
   end

   task automatic wait_grant(output logic [1:0] gv);
      gv = 2'b00;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (grant != 2'b00) begin
            gv = grant;
            break;
         end
      end
   endtask

   task automatic watch_done(input int drop_at, output int n_next, output int next_at,
                             output int rdy_at, output int done_at, output logic [1:0] dval);
      logic prev_rdy;
      n_next = 0; next_at = -1; rdy_at = -100; done_at = -1; dval = 2'b00;
      prev_rdy = dec_ready;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (i == drop_at) req = 2'b00;
         if (dec_next) begin
            n_next++;
            if (next_at < 0) next_at = i;
         end
         if (dec_ready && !prev_rdy) rdy_at = i;
         prev_rdy = dec_ready;
         if (done != 2'b00) begin
            dval = done;
            done_at = i;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef AES_DEC_ARB_RR_EN
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      reset = 1'b1; req = 2'b00; block0 = 128'h0; block1 = 128'h0;
      keylen0 = 1'b0; keylen1 = 1'b0; key_ready = 1'b1; dec_round = 4'h0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_grant", grant, 2'b00);
      check_eq("rst_done", done, 2'b00);
      check_eq("rst_dec_next", dec_next, 1'b0);
      check_eq("rst_result", result, 128'h0);
      check_eq("rst_dec_block", dec_block, 128'h0);
      check_eq("rst_dec_keylen", dec_keylen, 1'b0);
      reset = 1'b0;

      // single FIPS-197 AES-128 operation
      block0 = CT; keylen0 = 1'b0; req = 2'b01;
      wait_grant(g);
      check_eq("single_grant", g, 2'b01);
      check_eq("single_dec_block", dec_block, CT);
      watch_done(-1, nn, na, ra, da, dv);
      req = 2'b00;
      check_eq("single_next_count", nn, 1);
      check_eq("grant_to_next", na, 0);
      check_eq("single_done", dv, 2'b01);
      check_eq("ready_to_done", da - ra, 1);
      check_eq("single_result", result, PT);
      check_eq("single_block_held", dec_block, CT);
      @(negedge clk); #1;
      check_eq("done_one_cycle", done, 2'b00);
      check_eq("grant_released", grant, 2'b00);
      dec_round = 4'd3;  #1; check_eq("kr128_r3", key_round, 4'd7);
      dec_round = 4'd10; #1; check_eq("kr128_r10", key_round, 4'd0);
      dec_round = 4'd11; #1; check_eq("kr128_r11", key_round, 4'd0);

      // 256-bit operation on requester 1, then key index sweep
      block1 = B1; keylen1 = 1'b1; req = 2'b10;
      wait_grant(g);
      check_eq("k256_grant", g, 2'b10);
      check_eq("k256_dec_keylen", dec_keylen, 1'b1);
      watch_done(-1, nn, na, ra, da, dv);
      req = 2'b00;
      check_eq("k256_done", dv, 2'b10);
      check_eq("k256_result", result, dp_model(B1));
      for (int r = 0; r < 16; r++) begin
         dec_round = 4'(r);
         #1;
         check_eq("kr256_sweep", key_round, (r <= 14) ? 4'(14 - r) : 4'd0);
      end
      dec_round = 4'h0;

      // contention with both requesters held
      block0 = CT; keylen0 = 1'b0; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
         check_eq("contend_grant", g, exp_seq[k]);
         watch_done(-1, nn, na, ra, da, dv);
         check_eq("contend_done", dv, exp_seq[k]);
      end
      req = 2'b10;
      wait_grant(g);
      check_eq("contend_req1_only", g, 2'b10);
      watch_done(-1, nn, na, ra, da, dv);
      req = 2'b00;
      check_eq("contend_last_result", result, dp_model(B1));

      // key_ready gating
      key_ready = 1'b0; block0 = B2; req = 2'b01; cnt = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (grant != 2'b00) cnt++;
      end
      check_eq("gate_no_grant", cnt, 0);
      check_eq("result_hold", result, dp_model(B1));
      key_ready = 1'b1;
      @(negedge clk); #1;
      check_eq("gate_grant", grant, 2'b01);
      watch_done(-1, nn, na, ra, da, dv);
      req = 2'b00;
      check_eq("gate_done", dv, 2'b01);
      check_eq("gate_result", result, dp_model(B2));

      // owner drops req three cycles after grant
      block0 = B3; req = 2'b01;
      wait_grant(g);
      check_eq("abandon_grant", g, 2'b01);
      watch_done(2, nn, na, ra, da, dv);
      check_eq("abandon_done", dv, 2'b01);
      check_eq("abandon_result", result, dp_model(B3));
      check_eq("abandon_grant_clear", grant, 2'b00);

      // reset while waiting for the datapath
      block0 = CT; req = 2'b01;
      wait_grant(g);
      check_eq("rstop_grant", g, 2'b01);
      force_busy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk); #1;
      check_eq("rstop_grant_zero", grant, 2'b00);
      check_eq("rstop_next_zero", dec_next, 1'b0);
      check_eq("rstop_done_zero", done, 2'b00);
      check_eq("rstop_result_zero", result, 128'h0);
      reset = 1'b0; cnt = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (grant != 2'b00 || done != 2'b00) cnt++;
      end
      check_eq("rstop_wait_ready", cnt, 0);
      force_busy = 1'b0;
      wait_grant(g);
      check_eq("rstop_regrant", g, 2'b01);
      watch_done(-1, nn, na, ra, da, dv);
      req = 2'b00;
      check_eq("rstop_done", dv, 2'b01);
      check_eq("rstop_result", result, PT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
